dst: RTL and testbench

DST -- requirements
Module: dst

---
 rtl/dst_pkg.sv | 54 +++++
 rtl/dst_axis.sv | 80 ++++++++
 rtl/dst.sv | 102 ++++++++++
 tb/tb_dst.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_pkg.sv
// Shared timing constants, counter widths and phase decode for the display
// sync timing generator.
package dst_pkg;

    // Default horizontal timing, in pixel clocks.
    localparam int unsigned H_SYNC_DEF  = 32'd120;
    localparam int unsigned H_BP_DEF    = 32'd64;
    localparam int unsigned H_ACT_DEF   = 32'd800;
    localparam int unsigned H_FP_DEF    = 32'd56;
    localparam int unsigned H_TOTAL_DEF = H_SYNC_DEF + H_BP_DEF + H_ACT_DEF + H_FP_DEF;

    // Default vertical timing, in lines.
    localparam int unsigned V_SYNC_DEF  = 32'd6;
    localparam int unsigned V_BP_DEF    = 32'd23;
    localparam int unsigned V_ACT_DEF   = 32'd600;
    localparam int unsigned V_FP_DEF    = 32'd37;
    localparam int unsigned V_TOTAL_DEF = V_SYNC_DEF + V_BP_DEF + V_ACT_DEF + V_FP_DEF;

    // Default active level of hs and vs.
    localparam logic SYNC_POL_DEF = 1'b1;

    // Counter widths are fixed by the hcnt/vcnt ports.
    localparam int unsigned HCNT_W = 32'd11;
    localparam int unsigned VCNT_W = 32'd10;
    localparam int unsigned H_MAX  = 32'd2048;
    localparam int unsigned V_MAX  = 32'd1024;

    // Phases of a line or a frame, in the order they occur.
    typedef enum logic [1:0] {
        PH_SYNC = 2'd0,
        PH_BP   = 2'd1,
        PH_ACT  = 2'd2,
        PH_FP   = 2'd3
    } phase_e;

    // Map a position on an axis to the phase it falls in.
    function automatic phase_e phase_of(input int unsigned cnt,
                                        input int unsigned sync,
                                        input int unsigned bp,
                                        input int unsigned act);
        phase_e ph;
        if (cnt < sync) begin
            ph = PH_SYNC;
        end else if (cnt < sync + bp) begin
            ph = PH_BP;
        end else if (cnt < sync + bp + act) begin
            ph = PH_ACT;
        end else begin
            ph = PH_FP;
        end
        return ph;
    endfunction

endpackage

// File: rtl/dst_axis.sv
// One timing axis (horizontal or vertical): a wrapping position counter with
// sync, visible-window and terminal-count flags registered from the next count,
// so the flags line up with the count they describe.
module dst_axis
    import dst_pkg::*;
#(
    parameter int unsigned SYNC     = H_SYNC_DEF,
    parameter int unsigned BP       = H_BP_DEF,
    parameter int unsigned ACT      = H_ACT_DEF,
    parameter int unsigned FP       = H_FP_DEF,
    parameter int unsigned W        = HCNT_W,
    parameter logic        SYNC_POL = SYNC_POL_DEF
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         adv,      // advance enable for this axis
    input  logic         wrap_in,  // upstream axis is at its last count; tie high for the innermost axis
    output logic [W-1:0] count,
    output logic         wrap,     // this axis is at its last count
    output logic         sync,
    output logic         en
);

    localparam int unsigned  TOTAL     = SYNC + BP + ACT + FP;
    localparam logic [W-1:0] LAST      = W'(TOTAL - 32'd1);
    localparam logic [W-1:0] ONE       = W'(32'd1);
    // Flag values that correspond to position 0.
    localparam logic         RST_SYNC  = (SYNC > 32'd0) ? SYNC_POL : ~SYNC_POL;
    localparam logic         RST_EN    = (SYNC == 32'd0) && (BP == 32'd0) && (ACT > 32'd0);
    localparam logic         RST_WRAP  = (TOTAL == 32'd1);

    if ((TOTAL == 32'd0) || (TOTAL > (32'd1 << W))) begin : g_bad_total
        $error("dst_axis: total count %0d does not fit a %0d-bit counter", TOTAL, W);
    end

    logic [W-1:0] count_q, count_d;
    logic         sync_q, sync_d;
    logic         en_q, en_d;
    logic         wrap_q, wrap_d;
    phase_e       phase_s;

    // Next count and the decode of that next count.
    always_comb begin
        count_d = count_q;
        if (adv && wrap_in) begin
            if (wrap_q) begin
                count_d = '0;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
        phase_s = phase_of(32'(count_d), SYNC, BP, ACT);
        sync_d  = (phase_s == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        en_d    = (phase_s == PH_ACT);
        wrap_d  = (count_d == LAST);
    end

    // Count and flag registers with synchronous reset to position 0.
    always_ff @(posedge pclk) begin
        if (rst) begin
            count_q <= '0;
            sync_q  <= RST_SYNC;
            en_q    <= RST_EN;
            wrap_q  <= RST_WRAP;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign sync  = sync_q;
    assign en    = en_q;

endmodule

// File: rtl/dst.sv
// Display sync timing generator: horizontal and vertical axis counters with
// registered sync, visible-window and frame-start outputs, all advancing on ce.
module dst
    import dst_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_ACT    = H_ACT_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_ACT    = V_ACT_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter logic        SYNC_POL = SYNC_POL_DEF
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        ce,
    output logic        hs,
    output logic        vs,
    output logic        hen,
    output logic        ven,
    output logic [10:0] hcnt,
    output logic [9:0]  vcnt,
    output logic        fstart
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    if ((H_TOTAL == 32'd0) || (H_TOTAL > H_MAX)) begin : g_bad_h
        $error("dst: H_TOTAL %0d outside 1..%0d", H_TOTAL, H_MAX);
    end
    if ((V_TOTAL == 32'd0) || (V_TOTAL > V_MAX)) begin : g_bad_v
        $error("dst: V_TOTAL %0d outside 1..%0d", V_TOTAL, V_MAX);
    end

    logic h_wrap_s;
    logic v_wrap_s;
    logic v_adv_s;
    logic fstart_q, fstart_d;

    assign v_adv_s = ce && h_wrap_s;

    dst_axis #(
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .ACT      (H_ACT),
        .FP       (H_FP),
        .W        (HCNT_W),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .pclk    (pclk),
        .rst     (rst),
        .adv     (ce),
        .wrap_in (1'b1),
        .count   (hcnt),
        .wrap    (h_wrap_s),
        .sync    (hs),
        .en      (hen)
    );

    dst_axis #(
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .ACT      (V_ACT),
        .FP       (V_FP),
        .W        (VCNT_W),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .pclk    (pclk),
        .rst     (rst),
        .adv     (v_adv_s),
        .wrap_in (h_wrap_s),
        .count   (vcnt),
        .wrap    (v_wrap_s),
        .sync    (vs),
        .en      (ven)
    );

    // Next position is (0,0) exactly when both axes wrap on an enabled cycle.
    always_comb begin
        fstart_d = fstart_q;
        if (ce) begin
            fstart_d = h_wrap_s && v_wrap_s;
        end else begin
            fstart_d = fstart_q;
        end
    end

    // Frame-start register; reset lands on position (0,0).
    always_ff @(posedge pclk) begin
        if (rst) begin
            fstart_q <= 1'b1;
        end else begin
            fstart_q <= fstart_d;
        end
    end

    assign fstart = fstart_q;

endmodule

// File: tb/tb_dst.sv
// Bench for dst: three instances (default timing, a tiny timing for frame-level
// scenarios, and a 640-wide negative-sync override) checked cycle by cycle
// against a position model derived from the count of enabled cycles.
module tb_dst;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic rst_d = 1'b1, ce_d = 1'b0;
    logic rst_s = 1'b1, ce_s = 1'b0;
    logic rst_o = 1'b1, ce_o = 1'b0;

    logic hs_d, vs_d, hen_d, ven_d, fstart_d; logic [10:0] hcnt_d; logic [9:0] vcnt_d;
    logic hs_s, vs_s, hen_s, ven_s, fstart_s; logic [10:0] hcnt_s; logic [9:0] vcnt_s;
    logic hs_o, vs_o, hen_o, ven_o, fstart_o; logic [10:0] hcnt_o; logic [9:0] vcnt_o;

    logic [25:0] obs_d, obs_s, obs_o;
    assign obs_d = {hs_d, vs_d, hen_d, ven_d, fstart_d, hcnt_d, vcnt_d};
    assign obs_s = {hs_s, vs_s, hen_s, ven_s, fstart_s, hcnt_s, vcnt_s};
    assign obs_o = {hs_o, vs_o, hen_o, ven_o, fstart_o, hcnt_o, vcnt_o};

    dst u_def (
        .pclk(pclk), .rst(rst_d), .ce(ce_d), .hs(hs_d), .vs(vs_d), .hen(hen_d),
        .ven(ven_d), .hcnt(hcnt_d), .vcnt(vcnt_d), .fstart(fstart_d)
    );

    dst #(
        .H_SYNC(4), .H_BP(3), .H_ACT(10), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACT(5), .V_FP(3), .SYNC_POL(1'b1)
    ) u_small (
        .pclk(pclk), .rst(rst_s), .ce(ce_s), .hs(hs_s), .vs(vs_s), .hen(hen_s),
        .ven(ven_s), .hcnt(hcnt_s), .vcnt(vcnt_s), .fstart(fstart_s)
    );

    dst #(
        .H_SYNC(96), .H_BP(48), .H_ACT(640), .H_FP(16),
        .V_SYNC(2), .V_BP(2), .V_ACT(3), .V_FP(1), .SYNC_POL(1'b0)
    ) u_ovr (
        .pclk(pclk), .rst(rst_o), .ce(ce_o), .hs(hs_o), .vs(vs_o), .hen(hen_o),
        .ven(ven_o), .hcnt(hcnt_o), .vcnt(vcnt_o), .fstart(fstart_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Enabled cycles since the last reset, per instance.
    longint n_d = 0, n_s = 0, n_o = 0;

    // Expected outputs for instance k after n enabled cycles since reset.
    function automatic logic [25:0] model(input int k, input longint n);
        int hsy, hbp, hac, hfp, vsy, vbp, vac, vfp;
        logic pol;
        longint ht, vt, h, v;
        logic e_hs, e_vs, e_hen, e_ven, e_fs;
        case (k)
            1:       begin hsy = 4;   hbp = 3;  hac = 10;  hfp = 2;  vsy = 2; vbp = 2;  vac = 5;   vfp = 3;  pol = 1'b1; end
            2:       begin hsy = 96;  hbp = 48; hac = 640; hfp = 16; vsy = 2; vbp = 2;  vac = 3;   vfp = 1;  pol = 1'b0; end
            default: begin hsy = 120; hbp = 64; hac = 800; hfp = 56; vsy = 6; vbp = 23; vac = 600; vfp = 37; pol = 1'b1; end
        endcase
        ht = hsy + hbp + hac + hfp;
        vt = vsy + vbp + vac + vfp;
        h = n % ht;
        v = (n / ht) % vt;
        e_hs  = (h < hsy) ? pol : ~pol;
        e_vs  = (v < vsy) ? pol : ~pol;
        e_hen = (h >= hsy + hbp) && (h < hsy + hbp + hac);
        e_ven = (v >= vsy + vbp) && (v < vsy + vbp + vac);
        e_fs  = (h == 0) && (v == 0);
        return {e_hs, e_vs, e_hen, e_ven, e_fs, 11'(h), 10'(v)};
    endfunction

    // Advance one clock and update the enabled-cycle counts; returns 1 ns after the edge.
    task automatic step();
        @(posedge pclk);
        if (rst_d) n_d = 0; else if (ce_d) n_d++;
        if (rst_s) n_s = 0; else if (ce_s) n_s++;
        if (rst_o) n_o = 0; else if (ce_o) n_o++;
        #1;
    endtask

    task automatic test_reset();
        rst_d = 1'b1; ce_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_d !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 10'd0}) begin
                n_fail++; $display("FAIL reset_state: got %h expected %h", obs_d, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 10'd0});
            end
        end
        rst_d = 1'b0;
        step();
        n_checks++;
        if (hcnt_d !== 11'd1 || fstart_d !== 1'b0 || obs_d !== model(0, n_d)) begin
            n_fail++; $display("FAIL reset_release: got hcnt=%0d fstart=%b expected hcnt=1 fstart=0", hcnt_d, fstart_d);
        end
    endtask

    task automatic test_line();
        int hs_hi, hen_cnt, hen_first, hen_last;
        hs_hi = 0; hen_cnt = 0; hen_first = -1; hen_last = -1;
        rst_d = 1'b1; ce_d = 1'b1;
        step();
        rst_d = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            n_checks++;
            if (obs_d !== model(0, n_d)) begin
                n_fail++; $display("FAIL line_model c=%0d: got %h expected %h", c, obs_d, model(0, n_d));
            end
            if (c < 1040) begin
                if (hs_d === 1'b1) hs_hi++;
                if (hen_d === 1'b1) begin
                    hen_cnt++;
                    if (hen_first < 0) hen_first = c;
                    hen_last = c;
                end
            end
            if (c == 1040) begin
                n_checks++;
                if (vcnt_d !== 10'd1 || hcnt_d !== 11'd0) begin
                    n_fail++; $display("FAIL line_period: got h=%0d v=%0d expected h=0 v=1", hcnt_d, vcnt_d);
                end
            end
            step();
        end
        n_checks++;
        if (hs_hi != 120) begin n_fail++; $display("FAIL hs_width: got %0d expected 120", hs_hi); end
        n_checks++;
        if (hen_first != 184 || hen_last != 983 || hen_cnt != 800) begin
            n_fail++; $display("FAIL hen_window: got %0d..%0d (%0d) expected 184..983 (800)", hen_first, hen_last, hen_cnt);
        end
    endtask

    task automatic test_random_ce();
        for (int i = 0; i < 400; i++) begin
            ce_d = ($urandom_range(0, 2) != 0);
            step();
            n_checks++;
            if (obs_d !== model(0, n_d)) begin
                n_fail++; $display("FAIL random_ce i=%0d: got %h expected %h", i, obs_d, model(0, n_d));
            end
        end
        ce_d = 1'b0;
    endtask

    task automatic test_frame();
        int act, fs1, fs2, vs_lines;
        act = 0; fs1 = -1; fs2 = -1; vs_lines = 0;
        rst_s = 1'b1; ce_s = 1'b1;
        step();
        rst_s = 1'b0;
        for (int c = 0; c < 2 * 228 + 5; c++) begin
            n_checks++;
            if (obs_s !== model(1, n_s)) begin
                n_fail++; $display("FAIL frame_model c=%0d: got %h expected %h", c, obs_s, model(1, n_s));
            end
            if (c < 228 && hen_s === 1'b1 && ven_s === 1'b1) act++;
            if (c < 228 && hcnt_s == 11'd0 && vs_s === 1'b1) vs_lines++;
            if (c > 0 && fstart_s === 1'b1) begin
                if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
            end
            step();
        end
        n_checks++;
        if (act != 50) begin n_fail++; $display("FAIL active_count: got %0d expected 50", act); end
        n_checks++;
        if (fs1 != 228 || fs2 != 456) begin n_fail++; $display("FAIL fstart_period: got %0d,%0d expected 228,456", fs1, fs2); end
        n_checks++;
        if (vs_lines != 2) begin n_fail++; $display("FAIL vs_lines: got %0d expected 2", vs_lines); end
    endtask

    task automatic test_ce_wrap();
        rst_s = 1'b1; ce_s = 1'b1;
        step();
        rst_s = 1'b0;
        for (int i = 0; i < 227; i++) step();
        n_checks++;
        if (hcnt_s !== 11'd18 || vcnt_s !== 10'd11) begin
            n_fail++; $display("FAIL wrap_setup: got h=%0d v=%0d expected h=18 v=11", hcnt_s, vcnt_s);
        end
        ce_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (obs_s !== model(1, 227)) begin
                n_fail++; $display("FAIL ce_hold i=%0d: got %h expected %h", i, obs_s, model(1, 227));
            end
        end
        ce_s = 1'b1;
        step();
        n_checks++;
        if (hcnt_s !== 11'd0 || vcnt_s !== 10'd0 || fstart_s !== 1'b1) begin
            n_fail++; $display("FAIL ce_wrap: got h=%0d v=%0d fs=%b expected 0 0 1", hcnt_s, vcnt_s, fstart_s);
        end
        ce_s = 1'b0;
    endtask

    task automatic test_mid_reset();
        int k;
        rst_s = 1'b1; ce_s = 1'b1;
        step();
        rst_s = 1'b0;
        for (int i = 0; i < 104; i++) step();
        n_checks++;
        if (hcnt_s !== 11'd9 || vcnt_s !== 10'd5 || hen_s !== 1'b1 || ven_s !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got h=%0d v=%0d hen=%b ven=%b expected 9 5 1 1", hcnt_s, vcnt_s, hen_s, ven_s);
        end
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        n_checks++;
        if (hcnt_s !== 11'd0 || vcnt_s !== 10'd0 || hen_s !== 1'b0 || hs_s !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: got h=%0d v=%0d hen=%b hs=%b expected 0 0 0 1", hcnt_s, vcnt_s, hen_s, hs_s);
        end
        k = 0;
        do begin
            step();
            k++;
        end while (fstart_s !== 1'b1 && k < 1000);
        n_checks++;
        if (k != 228) begin n_fail++; $display("FAIL mid_reset_frame: got %0d cycles expected 228", k); end
        ce_s = 1'b0;
    endtask

    task automatic test_override();
        int hs_lo, hen_first, hen_last;
        hs_lo = 0; hen_first = -1; hen_last = -1;
        rst_o = 1'b1; ce_o = 1'b1;
        step();
        rst_o = 1'b0;
        for (int c = 0; c < 1700; c++) begin
            n_checks++;
            if (obs_o !== model(2, n_o)) begin
                n_fail++; $display("FAIL override_model c=%0d: got %h expected %h", c, obs_o, model(2, n_o));
            end
            if (c < 800) begin
                if (hs_o === 1'b0) hs_lo++;
                if (hen_o === 1'b1) begin
                    if (hen_first < 0) hen_first = c;
                    hen_last = c;
                end
            end
            if (c == 800) begin
                n_checks++;
                if (hcnt_o !== 11'd0 || vcnt_o !== 10'd1) begin
                    n_fail++; $display("FAIL override_period: got h=%0d v=%0d expected 0 1", hcnt_o, vcnt_o);
                end
            end
            step();
        end
        n_checks++;
        if (hs_lo != 96) begin n_fail++; $display("FAIL override_hs: got %0d expected 96", hs_lo); end
        n_checks++;
        if (hen_first != 144 || hen_last != 783) begin
            n_fail++; $display("FAIL override_hen: got %0d..%0d expected 144..783", hen_first, hen_last);
        end
        ce_o = 1'b0;
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 800; i++) begin
            rst_s = ($urandom_range(0, 79) == 0);
            ce_s  = ($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (obs_s !== model(1, n_s)) begin
                n_fail++; $display("FAIL random_mix i=%0d: got %h expected %h", i, obs_s, model(1, n_s));
            end
        end
        rst_s = 1'b0; ce_s = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst_s = 1'b0; rst_o = 1'b0;
        test_reset();
        test_line();
        test_random_ce();
        test_frame();
        test_ce_wrap();
        test_mid_reset();
        test_override();
        test_random_mix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
